// File: rtl/seq_det_param_if.sv
// Serial bit-stream link for the pattern detector: qualified input bit in, match pulse out.
interface seq_det_param_if;
    logic in;
    logic in_valid;
    logic out;

    modport master (output in, output in_valid, input out);
    modport slave  (input in, input in_valid, output out);
endinterface

// File: rtl/seq_det_param.sv
// Runtime-configurable serial pattern detector with overlap control and a saturating match counter.
module seq_det_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    seq_det_param_if.slave     bus,
    input  logic               overlap_en,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   pat_len
);

    logic [MAX_LEN-1:0] hist, hist_n, pat, len_mask;
    logic [LEN_W-1:0]   fill, fill_n, len, cfg_len_c;
    logic               accept, match;

    always_comb begin
        accept = bus.in_valid && !cfg_we;
        hist_n = {hist[MAX_LEN-2:0], bus.in};
        fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len));
        end
        // Only the newest len bits are compared; older history is masked off.
        match = accept && (fill_n >= len) && (((hist_n ^ pat) & len_mask) == '0);
        if (cfg_len == '0) begin
            cfg_len_c = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            cfg_len_c = LEN_W'(MAX_LEN);
        end else begin
            cfg_len_c = cfg_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist    <= '0;
            fill    <= '0;
            pat     <= '0;
            len     <= LEN_W'(MAX_LEN);
            bus.out <= 1'b0;
        end else if (cfg_we) begin
            pat     <= cfg_pattern;
            len     <= cfg_len_c;
            hist    <= '0;
            fill    <= '0;
            bus.out <= 1'b0;
        end else if (accept) begin
            hist    <= hist_n;
            // Non-overlap restarts the fill count so the next match needs len fresh bits.
            fill    <= (match && !overlap_en) ? '0 : fill_n;
            bus.out <= match;
        end else begin
            bus.out <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    assign pat_len = len;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: queue-based reference model plus literal per-step expectations.
module tb_seq_det_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int MAX8    = (1 << 8) - 1;
    localparam int MAX2    = (1 << 2) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_b = 1'b0, in_v = 1'b0, ovl = 1'b0, cfg_we = 1'b0, cnt_clr = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [7:0]         cnt8;
    logic [1:0]         cnt2;
    logic [LEN_W-1:0]   plen8, plen2;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    seq_det_param_if bus8();
    seq_det_param_if bus2();
    assign bus8.in = in_b;
    assign bus8.in_valid = in_v;
    assign bus2.in = in_b;
    assign bus2.in_valid = in_v;

    seq_det_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .overlap_en(ovl), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
        .match_cnt(cnt8), .pat_len(plen8)
    );
    seq_det_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .overlap_en(ovl), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
        .match_cnt(cnt2), .pat_len(plen2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: bits accepted since the last restart, matched against the pattern tail.
    bit          q[$];
    int          m_len = MAX_LEN;
    int          m_cnt8 = 0, m_cnt2 = 0;
    logic [MAX_LEN-1:0] m_pat = '0;
    logic        m_out = 1'b0;

    always @(posedge clk) begin : model
        bit hit;
        hit = 1'b0;
        if (!rst) begin
            q.delete();
            m_out = 1'b0; m_cnt8 = 0; m_cnt2 = 0; m_pat = '0; m_len = MAX_LEN;
        end else begin
            if (cfg_we) begin
                m_pat = cfg_pattern;
                m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
                q.delete();
                m_out = 1'b0;
            end else if (in_v) begin
                q.push_back(in_b);
                if (q.size() > MAX_LEN) void'(q.pop_front());
                if (q.size() >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !ovl) q.delete();
                m_out = hit;
            end else begin
                m_out = 1'b0;
            end
            if (cnt_clr) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (hit) begin
                if (m_cnt8 < MAX8) m_cnt8++;
                if (m_cnt2 < MAX2) m_cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out8", bus8.out, m_out);
            chk("model_out2", bus2.out, m_out);
            chk("model_cnt8", cnt8, m_cnt8);
            chk("model_cnt2", cnt2, m_cnt2);
            chk("model_len8", plen8, m_len);
            chk("model_len2", plen2, m_len);
        end
    end

    task automatic step(input logic v, input logic b, input logic exp_o, input string nm);
        in_v = v;
        in_b = b;
        @(posedge clk); #1;
        chk(nm, bus8.out, exp_o);
        in_v = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0; rst = 1'b1;
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l;
        step(1'b0, 1'b0, 1'b0, "cfg_out");
    endtask

    logic [5:0]  s_ovl_exp;
    logic [11:0] s_long;
    logic [1:0]  sat2 [6];

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_out", bus8.out, 0);
        chk("rst_cnt", cnt8, 0);
        chk("rst_len", plen8, MAX_LEN);
        rst = 1'b1;
        repeat (5) step(1'b0, 1'b0, 1'b0, "idle_out");

        // Overlap: 1,0,1,0,1 against 101
        ovl = 1'b1;
        cfg(8'b101, 4'd3);
        chk("len3", plen8, 3);
        s_ovl_exp = 6'b10100;
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2 == 0), s_ovl_exp[i], "ovl_out");
        chk("ovl_cnt", cnt8, 2);

        // Non-overlap: 1,0,1,0,1,0,1 -> pulses at bits 3 and 7
        ovl = 1'b0;
        cnt_clr = 1'b1;
        cfg(8'b101, 4'd3);
        chk("clr_cnt", cnt8, 0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'(i % 2 == 0), 1'(i == 2 || i == 6), "novl_out");
        chk("novl_cnt", cnt8, 2);

        // Valid gaps
        step(1'b1, 1'b1, 1'b0, "gap_out");
        repeat (3) step(1'b0, 1'b1, 1'b0, "gap_idle");
        step(1'b1, 1'b0, 1'b0, "gap_out");
        step(1'b1, 1'b1, 1'b1, "gap_hit");

        // Reconfig mid-pattern, in_valid on the cfg edge is discarded
        step(1'b1, 1'b1, 1'b0, "rcfg_out");
        step(1'b1, 1'b0, 1'b0, "rcfg_out");
        cfg_we = 1'b1; cfg_pattern = 8'b101; cfg_len = 4'd3;
        step(1'b1, 1'b1, 1'b0, "rcfg_edge");
        step(1'b1, 1'b0, 1'b0, "rcfg_out");
        step(1'b1, 1'b1, 1'b0, "rcfg_nohit");
        step(1'b1, 1'b0, 1'b0, "rcfg_out");
        step(1'b1, 1'b1, 1'b1, "rcfg_hit");

        // cfg_len=0 clamps to 1; every matching bit pulses in both modes
        ovl = 1'b1;
        cfg(8'h01, 4'd0);
        chk("len0", plen8, 1);
        step(1'b1, 1'b1, 1'b1, "len1_ovl");
        step(1'b1, 1'b1, 1'b1, "len1_ovl");
        step(1'b1, 1'b0, 1'b0, "len1_ovl");
        ovl = 1'b0;
        step(1'b1, 1'b1, 1'b1, "len1_novl");
        step(1'b1, 1'b0, 1'b0, "len1_novl");
        step(1'b1, 1'b1, 1'b1, "len1_novl");

        // Counter saturation (CNT_W=2) and clear coincident with a match
        cnt_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0, "clr_out");
        sat2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, "sat_out");
            chk("sat_cnt2", cnt2, sat2[i]);
            chk("sat_cnt8", cnt8, i + 1);
        end
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1, "clrhit_out");
        chk("clrhit_cnt8", cnt8, 0);
        chk("clrhit_cnt2", cnt2, 0);

        // Long pattern, cfg_len above MAX_LEN clamps to 8
        ovl = 1'b1;
        cfg(8'b11010011, 4'd15);
        chk("len_clamp", plen8, 8);
        s_long = 12'b110111010011;
        for (int i = 11; i >= 0; i--) step(1'b1, s_long[i], 1'(i == 0), "long_out");
        chk("long_cnt", cnt8, 1);

        // Reset mid-stream
        cfg(8'b11010011, 4'd8);
        for (int i = 7; i >= 3; i--) step(1'b1, s_long[i - 4 + 4], 1'b0, "pre_rst");
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, "rst_mid");
        chk("rst_mid_len", plen8, MAX_LEN);
        chk("rst_mid_cnt", cnt8, 0);
        step(1'b1, 1'b0, 1'b0, "post_rst");
        step(1'b1, 1'b1, 1'b0, "post_rst");
        step(1'b1, 1'b1, 1'b0, "post_rst");

        // fill saturation: after reset pat=0, len=8; overlapping zero run
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, "rst2");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'(i >= 7), "zero_run");
        chk("zero_cnt8", cnt8, 3);
        chk("zero_cnt2", cnt2, 3);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial bit-pattern detector; successor to the fixed three-bit detectors in the sequence-detector set. The pattern and its length (1..MAX_LEN) are loaded at runtime. Input bits are qualified by a valid strobe, and overlapping or non-overlapping matching is selectable. The block keeps a saturating match counter and sits directly on a serial bit stream; its registered match pulse drives downstream logic or a monitor.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2)
- CNT_W, 8: match counter width (≥1)
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived; do not override)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
- in  in  1  serial data bit
- in_valid  in  1  in accepted on a rising edge where in_valid=1
- overlap_en  in  1  1 = overlapping matches, 0 = non-overlapping
- cfg_we  in  1  load cfg_pattern/cfg_len on this edge
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last
- cfg_len  in  LEN_W  pattern length
- cnt_clr  in  1  clear match counter
- out  out  1  one-cycle registered match pulse
- match_cnt  out  CNT_W  saturating count of matches
- pat_len  out  LEN_W  currently active (clamped) length

## Operation
- State:
  - hist: MAX_LEN-bit shift register holding accepted bits; newest bit in [0].
  - fill: count of bits accepted since the last clear, saturating at MAX_LEN.
  - pat: active pattern register.
  - len: active length register.
- Reset (rst=0), applied on the edge:
  - hist=0, fill=0, out=0, match_cnt=0.
  - pat=0, len=MAX_LEN, pat_len=MAX_LEN.
- Config load (cfg_we=1, rst=1):
  - pat←cfg_pattern; len←clamp(cfg_len), where 0→1 and >MAX_LEN→MAX_LEN.
  - hist←0, fill←0, out←0 on that edge.
  - An in_valid on the same edge is discarded.
  - match_cnt is unaffected.
- Bit accept (in_valid=1, cfg_we=0):
  - hist_n={hist[MAX_LEN-2:0],in}; fill_n=min(fill+1,MAX_LEN).
  - match = (fill_n ≥ len) && (hist_n[len-1:0] == pat[len-1:0]); bits above len are ignored.
  - out←match.
  - On match with overlap_en=0: fill←0, so the next match needs len fresh bits. hist still shifts.
  - On match with overlap_en=1: fill←fill_n.
- No accept (in_valid=0, cfg_we=0): hist and fill hold; out←0.
- Counter:
  - On match, match_cnt←match_cnt+1, saturating at 2^CNT_W−1 (no wrap).
  - cnt_clr=1 forces match_cnt←0 and has priority over a simultaneous match; out still pulses.
- overlap_en may change at any time and takes effect on the next accepted bit.
- len=1 is legal: every accepted bit equal to pat[0] matches, in both modes.

## Timing
- Latency: out rises on the same clock edge that accepts the final pattern bit. It is visible in the cycle following that edge and lasts exactly one cycle.
- match_cnt updates on the same edge as out.
- Back-to-back in_valid is supported every cycle with no throughput loss.
- Priority order per edge: reset > cfg_we > in_valid. cnt_clr is independent of cfg_we and in_valid.
- Reset mid-stream discards all partial history; detection restarts from fill=0 after rst returns high.
- fill saturation: once fill=MAX_LEN it stays there in overlap mode; matching continues correctly for arbitrarily long streams.

## Test plan
- Reset values:
  - Stimulus: hold rst=0 for 2 edges, then release.
  - Required: out=0, match_cnt=0, pat_len=MAX_LEN; no out pulse for 5 idle cycles with in_valid=0.
- Overlap mode:
  - Stimulus: load pat=3'b101, len=3, overlap_en=1; stream 1,0,1,0,1 with in_valid=1 every cycle.
  - Required: out pulses after bits 3 and 5; match_cnt=2.
- Non-overlap mode:
  - Stimulus: same stream with overlap_en=0.
  - Required: out pulses after bit 3 only; match_cnt=1. Continuing with 0,1 gives a pulse after bit 7 and match_cnt=2.
- Valid gaps and reconfig:
  - Stimulus: stream 1,(in_valid=0 for 3 cycles),0,1.
  - Required: a single pulse on the edge accepting the final 1.
  - Stimulus: cfg_we mid-pattern after 1,0, then 1.
  - Required: no pulse.
  - Stimulus: cfg_len=0.
  - Required: pat_len=1.
- Counter saturation and clear:
  - Stimulus: CNT_W=2, len=1, pat=1; 6 consecutive 1s.
  - Required: match_cnt goes 1,2,3,3,3,3.
  - Stimulus: cnt_clr coincident with a match.
  - Required: match_cnt=0 and out=1.
- Long pattern and reset mid-stream:
  - Stimulus: MAX_LEN=8, pat=8'b11010011, len=8; pattern preceded by 1101.
  - Required: one pulse when the 8th pattern bit is accepted.
  - Stimulus: rst=0 pulse after 5 pattern bits, then the remaining 3 bits.
  - Required: no pulse.
